// File: rtl/delay_pkg.sv
// Shared types and sizing helpers for the delay_line ring-buffer controller.
`timescale 1ns/1ps

package delay_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_DATA_WIDTH    = 8;

    // The fill counter must reach N = 2**address_width, so it needs one extra bit.
    function automatic int fill_cnt_width(input int address_width);
        return address_width + 1;
    endfunction

endpackage

// File: rtl/delay_line_ram2ports.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
`timescale 1ns/1ps

module ram2ports #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    // NOTE: the array has no reset so it maps onto block RAM; non-blocking
    // assignments make a same-address read return the old word (read-before-write).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/delay_line.sv
// Ring-buffer delay controller around ram2ports with a fill gate on the output.
// Define DELAY_MIX_EN to output the average of the current and delayed sample.
`timescale 1ns/1ps

import delay_pkg::*;

module delay_line #(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid
);

    localparam int FW = fill_cnt_width(ADDRESS_WIDTH);
    localparam logic [FW-1:0] DEPTH = FW'(2**ADDRESS_WIDTH);

    state_t                  state;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [ADDRESS_WIDTH-1:0] offset_q;
    logic [FW-1:0]            fill_cnt;
    logic [FW-1:0]            delay;
    logic [DATA_WIDTH-1:0]    ram_dout;
    logic [DATA_WIDTH-1:0]    fresh;
    logic [DATA_WIDTH-1:0]    dout_hold;

    // An offset of zero selects the full buffer depth.
    assign delay   = (offset_q == '0) ? DEPTH : {1'b0, offset_q};
    assign rd_addr = wr_ptr - offset_q;

    ram2ports #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (en),
        .wr_addr(wr_ptr),
        .wr_data(din),
        .rd_en  (en),
        .rd_addr(rd_addr),
        .rd_data(ram_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            offset_q   <= offset;
            state      <= FILL;
            dout_valid <= 1'b0;
            dout_hold  <= '0;
        end else begin
            dout_valid <= 1'b0;
            dout_hold  <= dout;
            if (en) begin
                wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
            end
            // A new offset restarts the history count; the current sample is still stored.
            if (offset != offset_q) begin
                offset_q <= offset;
                fill_cnt <= '0;
                state    <= FILL;
            end else if (en) begin
                case (state)
                    FILL: begin
                        if (fill_cnt == delay) begin
                            state      <= RUN;
                            dout_valid <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + FW'(1);
                        end
                    end
                    RUN:     dout_valid <= 1'b1;
                    default: state      <= FILL;
                endcase
            end
        end
    end

`ifdef DELAY_MIX_EN
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH:0]   mix_sum;

    // din_q lines up with the RAM read so both halves of the mix refer to the same sample slot.
    always_ff @(posedge clk) begin
        if (en) begin
            din_q <= din;
        end
    end

    assign mix_sum = {1'b0, din_q} + {1'b0, ram_dout};
    assign fresh   = mix_sum[DATA_WIDTH:1];
`else
    assign fresh = ram_dout;
`endif

    // Between valid outputs dout replays the last valid value, so stale RAM reads never show.
    assign dout = dout_valid ? fresh : dout_hold;

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line: directed steps with a scoreboard of expected outputs.
`timescale 1ns/1ps

module tb_delay_line;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [AW-1:0] offset;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_valid;

    always #5 clk = ~clk;

    delay_line #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .offset    (offset),
        .din       (din),
        .dout      (dout),
        .dout_valid(dout_valid)
    );

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        string         tag;
    } exp_t;

    exp_t          sb[$];
    int            hist[$];
    int            n_cmp = 0;
    int            n_mis = 0;
    int            cnt   = 0;
    int            off_m = 0;
    logic [DW-1:0] last_m = '0;

    task automatic compare();
        exp_t x;
        x = sb.pop_front();
        n_cmp++;
        assert (dout_valid === x.valid) else begin
            n_mis++;
            $error("FAIL %s dout_valid: observed=%0b expected=%0b", x.tag, dout_valid, x.valid);
        end
        n_cmp++;
        assert (dout === x.data) else begin
            n_mis++;
            $error("FAIL %s dout: observed=%0d expected=%0d", x.tag, dout, x.data);
        end
    endtask

    // Drive one cycle of stimulus, predict the output from the sample history, then check it.
    task automatic step(input logic r, input logic e, input int off, input int d, input string tag);
        exp_t x;
        int   dly;
        int   delayed;
        rst    = r;
        en     = e;
        offset = AW'(off);
        din    = DW'(d);
        x.tag   = tag;
        x.valid = 1'b0;
        x.data  = last_m;
        if (r) begin
            cnt    = 0;
            off_m  = off;
            hist.delete();
            last_m = '0;
            x.data = '0;
        end else if (off != off_m) begin
            off_m = off;
            cnt   = 0;
            if (e) hist.push_back(d);
        end else if (e) begin
            dly = (off_m == 0) ? N : off_m;
            if (cnt >= dly) begin
                delayed = hist[hist.size() - dly];
`ifdef DELAY_MIX_EN
                x.data = DW'((d + delayed) >> 1);
`else
                x.data = DW'(delayed);
`endif
                x.valid = 1'b1;
                last_m  = x.data;
            end
            cnt++;
            hist.push_back(d);
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        // Reset state, including reset winning over en.
        step(1'b1, 1'b0, 3, 0,  "rst_idle");
        step(1'b1, 1'b1, 3, 99, "rst_en");

        // offset=3: first valid after the 4th sample, carrying sample 1.
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 3, i, "off3");

        // offset=1 with en toggling: idle cycles hold dout with no valid pulse.
        step(1'b0, 1'b0, 1, 0,  "chg_off1");
        step(1'b0, 1'b1, 1, 10, "tog_10");
        step(1'b0, 1'b0, 1, 0,  "tog_idle");
        step(1'b0, 1'b1, 1, 20, "tog_20");
        step(1'b0, 1'b0, 1, 0,  "tog_idle");
        step(1'b0, 1'b1, 1, 30, "tog_30");
        step(1'b0, 1'b0, 1, 0,  "tog_idle");

        // offset 2 then a mid-stream change to 5.
        for (int i = 0; i < 6; i++)  step(1'b0, 1'b1, 2, 40 + i, "off2");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 5, 60 + i, "off5");

        // Reset while outputs are valid; refill must hide stale RAM contents.
        step(1'b1, 1'b1, 5, 238, "rst_mid");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5, 100 + i, "refill");
        step(1'b0, 1'b0, 5, 7, "idle_hold");
        step(1'b0, 1'b0, 5, 7, "idle_hold");

        // offset=0 means full depth; ramp crosses the pointer wrap twice.
        step(1'b1, 1'b0, 0, 0, "rst_ramp");
        for (int i = 0; i <= 40; i++) step(1'b0, 1'b1, 0, i, "ramp");

        // Mixing corner cases (pure delay in the default build).
        step(1'b0, 1'b0, 1, 0,   "chg_mix");
        step(1'b0, 1'b1, 1, 200, "mix_200");
        step(1'b0, 1'b1, 1, 100, "mix_100");
        step(1'b0, 1'b1, 1, 255, "mix_255a");
        step(1'b0, 1'b1, 1, 255, "mix_255b");
        step(1'b0, 1'b0, 1, 0,   "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
